rx_bit_sampler: RTL and testbench
=================================

Name: rx_bit_sampler

Overview:
- Oversampling front end of the UART receiver.
- While enabled by the RX FSM, it counts oversampling edges within each bit period and counts bit periods within a frame.
- It takes three samples of rx_in around mid-bit and majority-votes them.
- It drives sampled_bit plus a one-cycle sample_valid strobe to the downstream start/parity/stop check stages and the deserializer. Those stages use sample_valid as their shift/check enable.

Parameters:
- PRESCALE_W, 6, width of the prescale input and edge counter; supports ratios up to 32.
- BIT_CNT_W, 4, width of the bit counter; frames up to 16 bit periods.

Ports:
- clk  input  1  oversampling clock (prescale x baud)
- rst  input  1  asynchronous active-low reset
- enable  input  1  from RX FSM; high = frame in progress, counters run
- rx_in  input  1  serial line, already synchronized to clk
- prescale  input  PRESCALE_W  oversampling ratio; supported values 8, 16, 32
- sampled_bit  output  1  registered majority-vote value of the current bit
- sample_valid  output  1  one-cycle strobe: sampled_bit updated for current bit
- edge_cnt  output  PRESCALE_W  oversampling edge index within current bit
- bit_cnt  output  BIT_CNT_W  bit period index within frame (0 = start bit)
- bit_done  output  1  high in the last edge cycle of a bit period

Behaviour:
- Reset (rst=0, async): edge_cnt=0, bit_cnt=0, sample regs s0=s1=1, sampled_bit=1 (idle line level), sample_valid=0. bit_done=0 follows from the rules below.
- enable=0 (synchronous clear): next edge sets edge_cnt=0, bit_cnt=0, sample_valid=0. sampled_bit holds its last value. No samples are taken.
- Edge counter: with enable=1, edge_cnt increments each clk.
  - When edge_cnt >= prescale-1, it wraps to 0 and bit_cnt increments.
  - The >= comparison means a prescale change mid-bit cannot lock up the counter.
- Bit counter: wraps modulo 2^BIT_CNT_W. The FSM guarantees frames fit in 16 bit periods.
- bit_done = enable && (edge_cnt == prescale-1). Combinational decode of registered state.
- Sampling: mid = prescale>>1.
  - At the clk edge where edge_cnt == mid-1, capture s0 <= rx_in.
  - At edge_cnt == mid, capture s1 <= rx_in.
  - At edge_cnt == mid+1, sampled_bit <= majority(s0, s1, rx_in) and sample_valid <= 1.
- sample_valid is therefore high for exactly one cycle, the cycle in which edge_cnt == mid+2. It is registered and cleared on the following edge.
  - prescale=8: samples at edges 3,4,5; valid during edge 6.
  - prescale=16: samples at edges 7,8,9; valid during edge 10.
  - prescale=32: samples at edges 15,16,17; valid during edge 18.
- Exactly one sample_valid per bit period. Never asserted while enable=0 or in reset.
- Mid-bit disable: if enable falls before edge mid+1, the partial bit produces no sample_valid. s0/s1 are not cleared but are overwritten before their next use.
- Reset mid-frame: all state returns to reset values immediately. There is no residual strobe.
- Unsupported prescale values (odd, <8, >32) need not sample correctly, but edge_cnt must still wrap and sample_valid must not repeat within a bit.
- Latency: sampled_bit valid 3 clk after the first sample edge. The total bit period equals prescale cycles exactly; there is no drift across a frame.

Test Plan:
- prescale=8, enable=1, rx_in=0 for 8 cycles then 1 for 8 -> bit 0: sampled_bit=0, sample_valid at edge 6. Bit 1: sampled_bit=1, bit_cnt 0->1 after edge 7; bit_done high at edges 7 and 15 only.
- prescale=16, rx_in=1 except a single-cycle 0 glitch at edge 8 -> sampled_bit=1 (majority). rx_in=0 at edges 7 and 8 only -> sampled_bit=0.
- prescale=32, 10-bit frame 0,1,0,1,1,0,0,1,0,1 -> ten sample_valid pulses during edge 18 of each bit, matching the sequence. bit_cnt reaches 9 and wraps edge_cnt 0..31 each bit.
- enable deasserted at edge 5 of a prescale=16 bit -> edge_cnt=0 and bit_cnt=0 next cycle, no sample_valid, sampled_bit unchanged. Re-enable restarts at edge 0.
- rst pulsed low at edge 4 of bit 3 (prescale=8) -> all outputs at reset values immediately. After release, no sample_valid until a full mid-bit window completes.
- 9-bit data+parity frame into the parity checker using sample_valid as its enable -> even-parity frame gives par_err=0; one flipped data bit gives par_err=1.

Source files
------------

// File: rtl/rx_bit_sampler.sv
// Purpose: UART RX oversampling front end; counts edges per bit and bits per frame,
//          majority-votes three mid-bit samples of rx_in.
// Latency: sampled_bit/sample_valid update 3 clk after the first sample edge (valid during edge mid+2).
// Backpressure: none; sample_valid is a one-cycle strobe that downstream stages must take when it is presented.
//
// Ports:
//   clk          oversampling clock (prescale x baud)
//   rst          asynchronous active-low reset
//   enable       frame in progress; low synchronously clears the counters
//   rx_in        serial line, already synchronized to clk
//   prescale     oversampling ratio (8, 16 or 32 sample correctly)
//   sampled_bit  registered majority-vote value of the current bit
//   sample_valid one-cycle strobe, sampled_bit updated for the current bit
//   edge_cnt     oversampling edge index within the current bit
//   bit_cnt      bit period index within the frame (0 = start bit)
//   bit_done     high in the last edge cycle of a bit period
module rx_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;
    logic                  wrap;
    logic                  vote;
    logic                  s0;
    logic                  s1;
    // Set once the current bit has produced its strobe. Guards against a second
    // strobe in the same bit if prescale changes mid-bit and moves the mid point.
    logic                  taken;

    assign last_edge = prescale - PRESCALE_W'(1);
    assign mid       = prescale >> 1;
    assign mid_m1    = mid - PRESCALE_W'(1);
    assign mid_p1    = mid + PRESCALE_W'(1);

    // >= rather than == so that shrinking prescale mid-bit still wraps.
    assign wrap      = (edge_cnt >= last_edge);
    assign vote      = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
    assign bit_done  = enable && (edge_cnt == last_edge);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            taken        <= 1'b0;
        end else if (!enable) begin
            // sampled_bit and s0/s1 hold; s0/s1 are rewritten before the next vote.
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            sample_valid <= 1'b0;
            taken        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            if (edge_cnt == mid_m1) begin
                s0 <= rx_in;
            end
            if (edge_cnt == mid) begin
                s1 <= rx_in;
            end
            if ((edge_cnt == mid_p1) && !taken) begin
                sampled_bit  <= vote;
                sample_valid <= 1'b1;
                taken        <= 1'b1;
            end

            // Placed after the sample logic so a wrap always re-arms the next bit.
            if (wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                taken    <= 1'b0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Purpose: directed bench for rx_bit_sampler with a scoreboard of expected votes.
// Latency: expected entries are popped when the DUT strobes sample_valid.
// Backpressure: none; the DUT has no ready input.
module tb_rx_bit_sampler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       rx_in;
    logic [5:0] prescale;
    logic       sampled_bit;
    logic       sample_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done;

    rx_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   vedge;
        int   bidx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic par_en = 1'b0;
    logic par_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_sample_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sampled_bit", {31'd0, sampled_bit}, {31'd0, e.b});
                check("valid_edge", {26'd0, edge_cnt}, e.vedge);
                check("valid_bit_cnt", {28'd0, bit_cnt}, e.bidx);
                if (par_en && bit_cnt >= 4'd1 && bit_cnt <= 4'd9)
                    par_acc = par_acc ^ sampled_bit;
            end
        end
    end

    // Drives nedges edges of one bit; pat[i] is rx_in during edge i.
    task automatic drive_bit(input int ps, input logic [31:0] pat, input int nedges,
                             input int bidx, input bit push, input logic exp);
        if (push) sb.push_back('{exp, ps / 2 + 2, bidx});
        prescale = 6'(ps);
        for (int i = 0; i < nedges; i++) begin
            rx_in = pat[i];
            check("edge_cnt", {26'd0, edge_cnt}, i);
            check("bit_cnt", {28'd0, bit_cnt}, bidx);
            check("bit_done", {31'd0, bit_done}, {31'd0, (i == ps - 1)});
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        rx_in  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        enable = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_edge_cnt"}, {26'd0, edge_cnt}, 32'd0);
        check({tag, "_bit_cnt"}, {28'd0, bit_cnt}, 32'd0);
        check({tag, "_sampled_bit"}, {31'd0, sampled_bit}, 32'd1);
        check({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        check({tag, "_bit_done"}, {31'd0, bit_done}, 32'd0);
    endtask

    // Sends start(0) + 8 data bits LSB first + parity at prescale 8.
    task automatic send_par_frame(input logic [7:0] data, input logic par);
        logic [9:0] fr;
        fr = {par, data, 1'b0};
        idle(1);
        par_acc = 1'b0;
        par_en  = 1'b1;
        for (int b = 0; b < 10; b++)
            drive_bit(8, {32{fr[b]}}, 8, b, 1'b1, fr[b]);
        par_en = 1'b0;
    endtask

    initial begin
        logic [9:0] seq;
        rst      = 1'b0;
        enable   = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        @(posedge clk); @(posedge clk); #1;
        check_reset_vals("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // prescale 8: bit 0 all zero, bit 1 all one
        enable = 1'b1;
        drive_bit(8, 32'h0000_0000, 8, 0, 1'b1, 1'b0);
        drive_bit(8, 32'hFFFF_FFFF, 8, 1, 1'b1, 1'b1);

        // prescale 16: single glitch at edge 8 is voted out; zeros at 7 and 8 win
        idle(1);
        drive_bit(16, 32'h0000_FEFF, 16, 0, 1'b1, 1'b1);
        drive_bit(16, 32'h0000_FE7F, 16, 1, 1'b1, 1'b0);

        // prescale 32: ten-bit frame
        idle(1);
        seq = 10'b10_1001_1010; // bit k = seq[k]: 0,1,0,1,1,0,0,1,0,1
        for (int b = 0; b < 10; b++)
            drive_bit(32, {32{seq[b]}}, 32, b, 1'b1, seq[b]);
        check("frame_bit_cnt_after", {28'd0, bit_cnt}, 32'd10);

        // prescale 16: disable during edge 5 of a zero bit
        drive_bit(16, 32'h0, 5, 10, 1'b0, 1'b0);
        enable = 1'b0;
        check("dis_bit_done", {31'd0, bit_done}, 32'd0);
        @(posedge clk); #1;
        check("dis_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        check("dis_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        check("dis_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("dis_sampled_bit_hold", {31'd0, sampled_bit}, 32'd1);
        @(posedge clk); #1;
        enable = 1'b1;
        drive_bit(16, 32'h0, 16, 0, 1'b1, 1'b0);

        // prescale 8: reset pulse during edge 4 of bit 3
        idle(1);
        drive_bit(8, 32'hFFFF_FFFF, 8, 0, 1'b1, 1'b1);
        drive_bit(8, 32'hFFFF_FFFF, 8, 1, 1'b1, 1'b1);
        drive_bit(8, 32'h0, 8, 2, 1'b1, 1'b0);
        drive_bit(8, 32'h0, 4, 3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        check_reset_vals("rst_hold");
        rst = 1'b1;
        drive_bit(8, 32'h0, 8, 0, 1'b1, 1'b0);

        // parity: data 8'h4D has four ones, even parity 0 -> no error
        send_par_frame(8'h4D, 1'b0);
        check("par_err_even", {31'd0, par_acc}, 32'd0);
        // one data bit flipped, same parity bit -> error
        send_par_frame(8'h4C, 1'b0);
        check("par_err_flip", {31'd0, par_acc}, 32'd1);

        idle(2);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
